// File: rtl/alu_mult_sequencer.sv
// Multi-cycle radix-2 shift-add multiply controller for the EX-stage ALU.
// Stalls the pipeline while a mult (ALUControl 3'b110) iterates, then pulses mul_done with the product.
module alu_mult_sequencer #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [2:0]       ALUControl,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             mul_done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MULT = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;

  logic               mul_req;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               last_iter;

  always_comb begin
    mul_req   = ex_valid && (ALUControl == OP_MULT) && !flush;
    addend    = mplier[0] ? mcand : '0;
    acc_nxt   = acc + addend;
    // Early exit fires once no set multiplier bits remain after this iteration.
    last_iter = (cnt == LAST) || ((EARLY_EXIT != 0) && ((mplier >> 1) == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      prod   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mul_req) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, src_a};
            mplier <= src_b;
            cnt    <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
              prod  <= acc_nxt;
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The request-cycle term is combinational so EX holds on the very cycle the mult is seen.
  always_comb begin
    busy     = (state == S_BUSY);
    stall    = !reset && (((state == S_IDLE) && mul_req) || (busy && !flush));
    mul_done = !reset && (state == S_DONE);
    prod_lo  = prod[WIDTH-1:0];
    prod_hi  = prod[2*WIDTH-1:WIDTH];
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: one instance without and one with early exit, sharing stimulus,
// checked every cycle against a transaction-level model plus directed literal cases.
module tb_alu_mult_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ex_valid = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   alu = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;

  logic [1:0]   s, d, bz;
  logic [W-1:0] lo [2];
  logic [W-1:0] hi [2];

  int total = 0;
  int bad = 0;

  alu_mult_sequencer #(.WIDTH(W), .EARLY_EXIT(0)) u_full (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALUControl(alu), .flush(flush),
    .src_a(src_a), .src_b(src_b), .stall(s[0]), .mul_done(d[0]),
    .prod_lo(lo[0]), .prod_hi(hi[0]), .busy(bz[0]));

  alu_mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1)) u_early (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALUControl(alu), .flush(flush),
    .src_a(src_a), .src_b(src_b), .stall(s[1]), .mul_done(d[1]),
    .prod_lo(lo[1]), .prod_hi(hi[1]), .busy(bz[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbusy(input bit ee, input logic [W-1:0] bv);
    if (!ee) return W;
    for (int i = W - 1; i >= 0; i--) if (bv[i]) return i + 1;
    return 1;
  endfunction

  // Model: remaining BUSY cycles, a DONE flag and the held product per instance.
  int          left  [2] = '{0, 0};
  bit          mdone [2] = '{0, 0};
  logic [63:0] mprod [2] = '{64'd0, 64'd0};
  logic [63:0] mpend [2] = '{64'd0, 64'd0};
  bit          armed = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        left[k] = 0; mdone[k] = 1'b0; mprod[k] = 64'd0;
      end else if (mdone[k]) begin
        mdone[k] = 1'b0;
      end else if (left[k] > 0) begin
        if (flush) left[k] = 0;
        else if (left[k] == 1) begin
          left[k] = 0; mdone[k] = 1'b1; mprod[k] = mpend[k];
        end else left[k] = left[k] - 1;
      end else if (ex_valid && alu == 3'b110 && !flush) begin
        left[k]  = nbusy(k == 1, src_b);
        mpend[k] = {32'd0, src_a} * {32'd0, src_b};
      end
    end
    if (reset) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        bit req, e_busy, e_idle, e_stall, e_done;
        req     = ex_valid && alu == 3'b110 && !flush;
        e_busy  = left[k] > 0;
        e_idle  = !e_busy && !mdone[k];
        e_stall = !reset && ((e_idle && req) || (e_busy && !flush));
        e_done  = mdone[k] && !reset;
        chk($sformatf("stall%0d", k), 64'(s[k]), 64'(e_stall));
        chk($sformatf("busy%0d", k), 64'(bz[k]), 64'(e_busy));
        chk($sformatf("done%0d", k), 64'(d[k]), 64'(e_done));
        chk($sformatf("prod%0d", k), {hi[k], lo[k]}, mprod[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    alu = 3'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin step(); idle_inputs(); end
  endtask

  // Issues one mult at cycle 0 and follows instance k until its mul_done pulse.
  task automatic run_mul(input string nm, input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_cyc, input int exp_stalls, input logic [63:0] exp_p);
    int cyc, stalls;
    logic [63:0] p;
    step();
    reset = 1'b0; flush = 1'b0; ex_valid = 1'b1; alu = 3'b110; src_a = a; src_b = b;
    cyc = -1; stalls = 0; p = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      stalls += int'(s[k]);
      if (d[k]) begin cyc = c; p = {hi[k], lo[k]}; break; end
      step();
      idle_inputs();
    end
    chk({nm, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    chk({nm, "_prod"}, p, exp_p);
  endtask

  initial begin
    logic [63:0] keep0, keep1;
    int ndone;
    repeat (3) @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk("rst_stall", 64'(s), 64'd0);
    chk("rst_busy", 64'(bz), 64'd0);
    chk("rst_done", 64'(d), 64'd0);
    chk("rst_prod0", {hi[0], lo[0]}, 64'd0);
    chk("rst_prod1", {hi[1], lo[1]}, 64'd0);

    run_mul("full_3x5", 0, 32'd3, 32'd5, 33, 33, 64'd15);
    settle(40);
    run_mul("early_7x5", 1, 32'd7, 32'd5, 4, 4, 64'd35);
    settle(40);
    run_mul("early_7x0", 1, 32'd7, 32'd0, 2, 2, 64'd0);
    settle(40);
    run_mul("early_ones", 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 33, 64'hFFFFFFFE_00000001);
    settle(40);

    for (int op = 0; op < 7; op++) begin
      step();
      ex_valid = (op != 6); alu = 3'(op); src_a = $urandom; src_b = $urandom;
      repeat (2) begin
        @(negedge clk);
        chk($sformatf("nonmult%0d_stall", op), 64'(s), 64'd0);
        chk($sformatf("nonmult%0d_busy", op), 64'(bz), 64'd0);
        chk($sformatf("nonmult%0d_done", op), 64'(d), 64'd0);
      end
    end
    settle(2);

    keep0 = {hi[0], lo[0]}; keep1 = {hi[1], lo[1]};
    step(); ex_valid = 1'b1; alu = 3'b110; src_a = 32'd9; src_b = 32'h80000000;
    repeat (3) begin step(); idle_inputs(); end
    step(); flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(s), 64'd0);
    chk("flush_busy_c4", 64'(bz), 64'd3);
    step(); flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_c5", 64'(bz), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step(); idle_inputs();
      @(negedge clk);
      ndone += int'(d[0]) + int'(d[1]);
    end
    chk("flush_nodone", 64'(ndone), 64'd0);
    chk("flush_keep0", {hi[0], lo[0]}, keep0);
    chk("flush_keep1", {hi[1], lo[1]}, keep1);

    step(); ex_valid = 1'b1; alu = 3'b110; src_a = 32'd5; src_b = 32'hFFFFFFFF;
    repeat (2) begin step(); idle_inputs(); end
    step(); reset = 1'b1;
    @(negedge clk);
    chk("rstbusy_stall", 64'(s), 64'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("rstbusy_outs", {58'd0, s, d, bz}, 64'd0);
    chk("rstbusy_prod0", {hi[0], lo[0]}, 64'd0);
    chk("rstbusy_prod1", {hi[1], lo[1]}, 64'd0);
    settle(40);

    run_mul("b2b_12x12", 1, 32'd12, 32'd12, 5, 5, 64'd144);
    run_mul("b2b_2x3", 1, 32'd2, 32'd3, 3, 3, 64'd6);
    settle(40);

    for (int i = 0; i < 4000; i++) begin
      int r;
      step();
      ex_valid = ($urandom % 4) != 0;
      alu      = (($urandom % 3) == 0) ? 3'b110 : 3'($urandom);
      flush    = ($urandom % 20) == 0;
      reset    = ($urandom % 300) == 0;
      src_a    = (($urandom % 6) == 0) ? 32'hFFFFFFFF : $urandom;
      r = int'($urandom % 5);
      case (r)
        0:       src_b = 32'd0;
        1:       src_b = 32'hFFFFFFFF;
        2:       src_b = $urandom % 256;
        3:       src_b = 32'd1 << ($urandom % 32);
        default: src_b = $urandom;
      endcase
    end
    settle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
